// File: rtl/cmos_switch_sync.sv
// cmos_switch_sync: frame-aligned switch that routes one of CH_NUM synchronous CMOS streams to one output.
// Latency: data, dreq and vsync leave 1 cycle after they enter. Status outputs are registered.
// Backpressure: none. A switch waits for frame boundaries on the old and new channels, and i_sw_en gates the stream outputs.
//
// Ports:
//   i_clk, i_rst        sole clock; asynchronous active-high reset
//   i_sw_en             output enable; 0 zeroes data/dreq/vsync outputs (FSM keeps running)
//   i_eth_cmos_sel      requested channel (values >= CH_NUM are rejected with o_sel_err)
//   i_cmos_data/dreq/vsync  per-channel streams, channel n at [n*DATA_W +: DATA_W] / bit n
//   o_cmos_sel_*        selected stream
//   o_cur_ch, o_busy    routed channel; high while a switch is pending
//   o_sw_done, o_sel_err, o_timeout  single-cycle pulses
// Build option: define CMOS_SW_TIMEOUT_EN to force a pending switch after TIMEOUT_CYC cycles.
module cmos_switch_sync #(
  parameter int CH_NUM      = 9,
  parameter int DATA_W      = 32,
  parameter int CH_W        = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sw_en,
  input  logic [CH_W-1:0]          i_eth_cmos_sel,
  input  logic [CH_NUM*DATA_W-1:0] i_cmos_data,
  input  logic [CH_NUM-1:0]        i_cmos_dreq,
  input  logic [CH_NUM-1:0]        i_cmos_vsync,
  output logic [DATA_W-1:0]        o_cmos_sel_data,
  output logic                     o_cmos_sel_dreq,
  output logic                     o_cmos_sel_vsync,
  output logic [CH_W-1:0]          o_cur_ch,
  output logic                     o_busy,
  output logic                     o_sw_done,
  output logic                     o_sel_err,
  output logic                     o_timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, WAIT = 2'd2} state_e;

  // Elaboration-time parameter sanity checks.
  if (CH_NUM < 2 || CH_NUM > 16 || (1 << CH_W) < CH_NUM || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("cmos_switch_sync: illegal parameter combination");
  end

  localparam logic [CH_W:0] CH_NUM_L = (CH_W+1)'(CH_NUM);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     cur_q, cur_d, tgt_q, tgt_d;
  logic [CH_NUM-1:0]   vs_dly_q;
  logic [CH_NUM-1:0]   vs_rise;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dreq_q, dreq_d, vsync_q, vsync_d;
  logic                done_q, done_d, err_q, err_d;
  // Last rejected select, so an out-of-range value reports only once until it changes.
  logic [CH_W-1:0]     err_sel_q, err_sel_d;
  logic                err_seen_q, err_seen_d;

  logic [DATA_W-1:0]   cur_dat, tgt_dat;
  logic                cur_dreq, cur_vs, cur_rise, tgt_dreq, tgt_vs, tgt_rise;
  logic                sel_valid;

  assign vs_rise   = i_cmos_vsync & ~vs_dly_q;
  assign sel_valid = ({1'b0, i_eth_cmos_sel} < CH_NUM_L);

  // Channel muxes for the current and the pending target channel.
  always_comb begin
    cur_dat = '0; cur_dreq = 1'b0; cur_vs = 1'b0; cur_rise = 1'b0;
    tgt_dat = '0; tgt_dreq = 1'b0; tgt_vs = 1'b0; tgt_rise = 1'b0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (cur_q == CH_W'(n)) begin
        cur_dat  = i_cmos_data[n*DATA_W +: DATA_W];
        cur_dreq = i_cmos_dreq[n];
        cur_vs   = i_cmos_vsync[n];
        cur_rise = vs_rise[n];
      end
      if (tgt_q == CH_W'(n)) begin
        tgt_dat  = i_cmos_data[n*DATA_W +: DATA_W];
        tgt_dreq = i_cmos_dreq[n];
        tgt_vs   = i_cmos_vsync[n];
        tgt_rise = vs_rise[n];
      end
    end
  end

`ifdef CMOS_SW_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_q;
  logic            to_hit;
  // to_cnt_q equals the number of completed cycles since DRAIN was entered.
  assign to_hit = (state_q != RUN) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_sel_d  = err_sel_q;
    err_seen_d = err_seen_q;
    data_d     = cur_dat;
    dreq_d     = cur_dreq;
    vsync_d    = cur_vs;
    case (state_q)
      RUN: begin
        if (sel_valid) begin
          err_seen_d = 1'b0;
          if (i_eth_cmos_sel != cur_q) begin
            tgt_d   = i_eth_cmos_sel;
            state_d = DRAIN;
          end
        end else begin
          if (!(err_seen_q && err_sel_q == i_eth_cmos_sel)) err_d = 1'b1;
          err_seen_d = 1'b1;
          err_sel_d  = i_eth_cmos_sel;
        end
      end
      DRAIN: begin
        // Only the current channel's frame start matters here, even if the target starts too.
        if (cur_rise) begin
          dreq_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        data_d  = '0;
        dreq_d  = 1'b0;
        vsync_d = tgt_vs;
        if (tgt_rise) begin
          // Target frame starts now: its first beat goes out with the done pulse.
          data_d  = tgt_dat;
          dreq_d  = tgt_dreq;
          cur_d   = tgt_q;
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
`ifdef CMOS_SW_TIMEOUT_EN
    if (to_hit) begin
      data_d  = tgt_dat;
      dreq_d  = tgt_dreq;
      vsync_d = tgt_vs;
      cur_d   = tgt_q;
      state_d = RUN;
      done_d  = 1'b0;
    end
`endif
    if (!i_sw_en) begin
      data_d  = '0;
      dreq_d  = 1'b0;
      vsync_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= RUN;
      cur_q      <= '0;
      tgt_q      <= '0;
      vs_dly_q   <= '0;
      data_q     <= '0;
      dreq_q     <= 1'b0;
      vsync_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_sel_q  <= '0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      vs_dly_q   <= i_cmos_vsync;
      data_q     <= data_d;
      dreq_q     <= dreq_d;
      vsync_q    <= vsync_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_sel_q  <= err_sel_d;
      err_seen_q <= err_seen_d;
    end
  end

`ifdef CMOS_SW_TIMEOUT_EN
  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (state_q == RUN || state_d == RUN) to_cnt_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_hit;
    end
  end

  assign o_timeout = to_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_cmos_sel_data  = data_q;
  assign o_cmos_sel_dreq  = dreq_q;
  assign o_cmos_sel_vsync = vsync_q;
  assign o_cur_ch         = cur_q;
  assign o_busy           = (state_q != RUN);
  assign o_sw_done        = done_q;
  assign o_sel_err        = err_q;

endmodule

// File: tb/tb_cmos_switch_sync.sv
// Directed bench for cmos_switch_sync: reset, routing, frame-aligned switching, select errors, gating.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_cmos_switch_sync;
  localparam int CH_NUM = 9;
  localparam int DATA_W = 32;
  localparam int CH_W   = 4;
  localparam int TO_CYC = 64;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sw_en;
  logic [CH_W-1:0]          sel;
  logic [CH_NUM*DATA_W-1:0] cmos_data;
  logic [CH_NUM-1:0]        cmos_dreq, cmos_vsync;
  logic [DATA_W-1:0]        o_data;
  logic                     o_dreq, o_vsync, o_busy, o_done, o_err, o_to;
  logic [CH_W-1:0]          o_cur;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmos_switch_sync #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .CH_W(CH_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_en(sw_en), .i_eth_cmos_sel(sel),
    .i_cmos_data(cmos_data), .i_cmos_dreq(cmos_dreq), .i_cmos_vsync(cmos_vsync),
    .o_cmos_sel_data(o_data), .o_cmos_sel_dreq(o_dreq), .o_cmos_sel_vsync(o_vsync),
    .o_cur_ch(o_cur), .o_busy(o_busy), .o_sw_done(o_done), .o_sel_err(o_err), .o_timeout(o_to)
  );

  function automatic logic [31:0] pat(input int ch, input int k);
    return {8'(ch + 1), 8'(k), 16'hA5C3 ^ 16'(ch)};
  endfunction

  task automatic set_data(input int k);
    for (int n = 0; n < CH_NUM; n++) cmos_data[n*DATA_W +: DATA_W] = pat(n, k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Status outputs in one call: busy, current channel, and the three pulses.
  task automatic chk_st(input string tag, input logic busy, input int cur,
                        input logic done, input logic err, input logic to);
    chk({tag, ".busy"}, 32'(o_busy), 32'(busy));
    chk({tag, ".cur"},  32'(o_cur),  32'(cur));
    chk({tag, ".done"}, 32'(o_done), 32'(done));
    chk({tag, ".err"},  32'(o_err),  32'(err));
    chk({tag, ".to"},   32'(o_to),   32'(to));
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic dq, input logic vs);
    chk({tag, ".data"},  o_data,         d);
    chk({tag, ".dreq"},  32'(o_dreq),    32'(dq));
    chk({tag, ".vsync"}, 32'(o_vsync),   32'(vs));
  endtask

  initial begin
    rst = 1'b1; sw_en = 1'b1; sel = '0;
    cmos_dreq = '1; cmos_vsync = '0; set_data(1);
    #3;
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    chk_st("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    // Reset release: channel 0 appears one cycle later.
    step();
    chk_out("rel", pat(0, 1), 1'b1, 1'b0);
    chk_st("rel", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    set_data(2); cmos_dreq = 9'h1FE; cmos_vsync = 9'h001;
    step();
    chk_out("run2", pat(0, 2), 1'b0, 1'b1);
    cmos_dreq = '1; cmos_vsync = '0;

    // Output gating for 10 cycles while routing channel 0.
    sw_en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      set_data(20 + i); cmos_vsync = 9'(i & 1);
      step();
      chk_out("gate", 32'h0, 1'b0, 1'b0);
      chk("gate.cur", 32'(o_cur), 32'd0);
    end
    sw_en = 1'b1; cmos_vsync = '0; set_data(3);
    step();
    chk_out("ungate", pat(0, 3), 1'b1, 1'b0);

    // Out-of-range select: one error pulse, no switch.
    sel = 4'd12;
    step();
    chk_st("sel12a", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk_st("sel12b", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step();
    chk_st("sel12c", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Switch 0 -> 3 mid-frame.
    sel = 4'd3; set_data(10);
    step();
    chk_st("drain1", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk_out("drain1", pat(0, 10), 1'b1, 1'b0);
    set_data(11);
    step();
    chk_out("drain2", pat(0, 11), 1'b1, 1'b0);
    // Both channels start a frame together: only the ch0 edge counts.
    cmos_vsync = 9'h009;
    step();
    chk("edge0.dreq", 32'(o_dreq), 32'd0);
    chk_st("edge0", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    cmos_vsync = '0; set_data(12);
    step();
    chk_out("wait1", 32'h0, 1'b0, 1'b0);
    chk_st("wait1", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    // Select change and old-channel vsync are ignored in WAIT.
    sel = 4'd5; cmos_vsync = 9'h001;
    step();
    chk_out("wait2", 32'h0, 1'b0, 1'b0);
    chk_st("wait2", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    sel = 4'd3; cmos_vsync = 9'h008; set_data(13);
    step();
    chk_out("done", pat(3, 13), 1'b1, 1'b1);
    chk_st("done", 1'b0, 3, 1'b1, 1'b0, 1'b0);
    cmos_vsync = '0; set_data(14);
    step();
    chk_out("ch3", pat(3, 14), 1'b1, 1'b0);
    chk_st("ch3", 1'b0, 3, 1'b0, 1'b0, 1'b0);

    // Reset while waiting on the target frame.
    sel = 4'd0;
    step();
    chk("rw.busy", 32'(o_busy), 32'd1);
    cmos_vsync = 9'h008;
    step();
    cmos_vsync = '0;
    step();
    chk("rw.wait", 32'(o_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_out("rw.rst", 32'h0, 1'b0, 1'b0);
    chk_st("rw.rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0; set_data(15);
    step();
    chk_out("rw.rel", pat(0, 15), 1'b1, 1'b0);
    chk_st("rw.rel", 1'b0, 0, 1'b0, 1'b0, 1'b0);

`ifdef CMOS_SW_TIMEOUT_EN
    // Switch to channel 2 which never starts a frame: forced after TO_CYC cycles.
    sel = 4'd2;
    step();
    chk("to.busy", 32'(o_busy), 32'd1);
    for (int i = 1; i < TO_CYC; i++) begin
      step();
      chk("to.wait", 32'(o_to), 32'd0);
    end
    step();
    chk_st("to.hit", 1'b0, 2, 1'b0, 1'b0, 1'b1);
    step();
    chk("to.pulse", 32'(o_to), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
